i2c_byte_transmitter: RTL and testbench

Single-master I2C write transmitter. It accepts one parallel byte over a valid/ready handshake, then drives a complete bus write: START, 7-bit address plus W bit, ACK check, data byte, ACK check, STOP. It is the sending end for the FullI2CController receive path: its SDA_OUT/SCL_OUT feed that block's serial DATA input and clock.

---
 rtl/i2c_byte_transmitter.sv | 168 ++++++++++++++++
 tb/tb_i2c_byte_transmitter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_transmitter.sv
`default_nettype none
// ============================================================================
// i2c_byte_transmitter : single-master I2C write (START, addr+W, data, STOP).
// Optional I2C_TX_BURST_EN chains further bytes on ACK2 without STOP/START.
// Revision: 1.0
// ============================================================================
module i2c_byte_transmitter #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [6:0]  ADDR    = 7'h50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic       SDA_IN,
  output logic       SDA_OUT,
  output logic       SCL_OUT,
  output logic       BUSY,
  output logic       ACK_ERR
);

  localparam int unsigned        c_div_w     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_one   = c_div_w'(1);
  localparam logic [7:0]         c_addr_byte = {ADDR, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_ACK1  = 3'd3,
    S_DATA  = 3'd4,
    S_ACK2  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [c_div_w-1:0] div_q, div_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         data_q, data_d;
  logic               ack_err_q, ack_err_d;
`ifdef I2C_TX_BURST_EN
  logic               pend_q, pend_d;
`endif

  logic w_tick;
  logic w_slot_end;
  logic w_ack_sample;

  assign w_tick       = (div_q == c_div_last);
  assign w_slot_end   = w_tick && (qtr_q == 2'd3);
  assign w_ack_sample = w_tick && (qtr_q == 2'd2);
  assign ACK_ERR      = ack_err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd7;
      data_q    <= 8'd0;
      ack_err_q <= 1'b0;
`ifdef I2C_TX_BURST_EN
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      ack_err_q <= ack_err_d;
`ifdef I2C_TX_BURST_EN
      pend_q    <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
`ifdef I2C_TX_BURST_EN
    pend_d    = 1'b0;
`endif
    TX_READY  = 1'b0;
    BUSY      = 1'b1;
    SCL_OUT   = qtr_q[1];
    SDA_OUT   = 1'b1;

    // The divider and quarter counter free-run in every bit slot; the 2-bit add wraps 3->0.
    if (w_tick) begin
      div_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      div_d = div_q + c_div_one;
    end

    case (state_q)
      S_IDLE: begin
        TX_READY = 1'b1;
        BUSY     = 1'b0;
        SCL_OUT  = 1'b1;
        div_d    = '0;
        qtr_d    = 2'd0;
        if (TX_VALID) begin
          data_d    = TX_DATA;
          ack_err_d = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        SCL_OUT = 1'b1;
        SDA_OUT = ~qtr_q[1];
        if (w_slot_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        SDA_OUT = c_addr_byte[bit_q];
        if (w_slot_end) begin
          if (bit_q == 3'd0) state_d = S_ACK1;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_ACK1: begin
        if (w_ack_sample && SDA_IN) ack_err_d = 1'b1;
        if (w_slot_end) state_d = ack_err_q ? S_STOP : S_DATA;
      end
      S_DATA: begin
        SDA_OUT = data_q[bit_q];
        if (w_slot_end) begin
          if (bit_q == 3'd0) state_d = S_ACK2;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_ACK2: begin
        if (w_ack_sample && SDA_IN) ack_err_d = 1'b1;
`ifdef I2C_TX_BURST_EN
        // A byte accepted in q3 is held pending until the slot completes.
        TX_READY = (qtr_q == 2'd3) && !ack_err_q && !pend_q;
        pend_d   = pend_q;
        if (TX_VALID && TX_READY) begin
          data_d = TX_DATA;
          pend_d = 1'b1;
        end
        if (w_slot_end) state_d = (pend_q || (TX_VALID && TX_READY)) ? S_DATA : S_STOP;
`else
        if (w_slot_end) state_d = S_STOP;
`endif
      end
      S_STOP: begin
        SDA_OUT = (qtr_q == 2'd3);
        if (w_slot_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) bit_d = 3'd7;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_transmitter.sv
`default_nettype none
// tb_i2c_byte_transmitter : directed + randomized bench; expected bus traffic is
// derived from the transaction contents (bits seen at SCL rise, START/STOP count, length).
module tb_i2c_byte_transmitter;

  localparam int         CLK_DIV = 2;
  localparam logic [6:0] ADDR    = 7'h50;

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic [7:0] TX_DATA  = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic       SDA_IN   = 1'b1;
  logic       SDA_OUT;
  logic       SCL_OUT;
  logic       BUSY;
  logic       ACK_ERR;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  i2c_byte_transmitter #(.CLK_DIV(CLK_DIV), .ADDR(ADDR)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .TX_DATA (TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .SDA_IN  (SDA_IN),
    .SDA_OUT (SDA_OUT),
    .SCL_OUT (SCL_OUT),
    .BUSY    (BUSY),
    .ACK_ERR (ACK_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus write. The slave answers nack1/nack2 in the ACK slots; toggle hammers
  // TX_VALID while busy; burst2 offers d2 for chaining; rst_at>0 resets the DUT at the
  // SCL fall that follows that many SCL rises.
  task automatic run_txn(input logic [7:0] d, input logic nack1, input logic nack2,
                         input logic toggle, input logic burst2, input logic [7:0] d2,
                         input int rst_at);
    logic [7:0]  abyte;
    logic [31:0] expv, got;
    int          expn, nrise, starts, stops, busy, rdy_busy;
    logic        pscl, psda, acc, timeout, rst_done;

    // Reference: the level on SDA at every SCL rise, in order.
    abyte = {ADDR, 1'b0};
    expv  = 32'd0;
    for (int i = 7; i >= 0; i--) expv = {expv[30:0], abyte[i]};
    expv = {expv[30:0], 1'b1};
    expn = 9;
    if (!nack1) begin
      for (int i = 7; i >= 0; i--) expv = {expv[30:0], d[i]};
      expv = {expv[30:0], 1'b1};
      expn += 9;
      if (burst2 && !nack2) begin
        for (int i = 7; i >= 0; i--) expv = {expv[30:0], d2[i]};
        expv = {expv[30:0], 1'b1};
        expn += 9;
      end
    end
    expv = {expv[30:0], 1'b0};
    expn += 1;

    @(negedge CLK);
    chk("ready_idle", TX_READY, 1);
    TX_DATA  = d;
    TX_VALID = 1'b1;
    @(negedge CLK);
    chk("busy_after_hs", BUSY, 1);
    chk("ready_after_hs", TX_READY, 0);
    chk("ackerr_cleared", ACK_ERR, 0);
    TX_VALID = burst2;
    TX_DATA  = burst2 ? d2 : 8'($urandom);

    got = 0; nrise = 0; starts = 0; stops = 0; busy = 1; rdy_busy = 0;
    pscl = SCL_OUT; psda = SDA_OUT; acc = 1'b0; timeout = 1'b1; rst_done = 1'b0;
    SDA_IN = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      if (acc) begin
        TX_VALID = 1'b0;
        acc      = 1'b0;
      end
      if (!BUSY) begin
        timeout = 1'b0;
        break;
      end
      busy++;
      if (SCL_OUT && !pscl) begin
        got = {got[30:0], SDA_OUT};
        nrise++;
      end else if (SCL_OUT && pscl && psda && !SDA_OUT) begin
        starts++;
      end else if (SCL_OUT && pscl && !psda && SDA_OUT) begin
        stops++;
      end
      if (nrise > 0 && nrise % 9 == 0)
        SDA_IN = (nrise == 9) ? nack1 : (nrise == 18) ? nack2 : 1'b0;
      else
        SDA_IN = 1'b1;
      if (TX_READY) rdy_busy++;
      if (burst2 && TX_VALID && TX_READY) acc = 1'b1;
      if (toggle) begin
        TX_VALID = ~TX_VALID;
        TX_DATA  = 8'($urandom);
      end
      if (rst_at != 0 && nrise == rst_at && !SCL_OUT && pscl) begin
        RST = 1'b1;
        #1;
        chk("rst_sda", SDA_OUT, 1);
        chk("rst_scl", SCL_OUT, 1);
        chk("rst_ready", TX_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_ackerr", ACK_ERR, 0);
        @(negedge CLK);
        RST      = 1'b0;
        rst_done = 1'b1;
        break;
      end
      pscl = SCL_OUT;
      psda = SDA_OUT;
    end
    TX_VALID = 1'b0;
    SDA_IN   = 1'b1;
    if (rst_done) return;

    chk("timeout", timeout, 0);
    chk("scl_rises", nrise, expn);
    chk("sda_bits", got, expv);
    chk("start_count", starts, 1);
    chk("stop_count", stops, 1);
    chk("busy_cycles", busy, (expn + 1) * 4 * CLK_DIV);
    chk("ack_err", ACK_ERR, nack1 | nack2);
    chk("ready_at_idle", TX_READY, 1);
`ifndef I2C_TX_BURST_EN
    chk("ready_while_busy", rdy_busy, 0);
`endif
  endtask

  initial begin
    logic [7:0] rd;
    logic       n1, n2, tg;

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (50) @(negedge CLK);
    chk("idle_scl", SCL_OUT, 1);
    chk("idle_sda", SDA_OUT, 1);
    chk("idle_ready", TX_READY, 1);
    chk("idle_busy", BUSY, 0);
    chk("idle_ackerr", ACK_ERR, 0);

    run_txn(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    run_txn(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    run_txn(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
`ifndef I2C_TX_BURST_EN
    run_txn(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
`endif
    run_txn(8'hE7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11);
    run_txn(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    run_txn(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0);

    for (int t = 0; t < 6; t++) begin
      rd = 8'($urandom);
      n1 = ($urandom_range(0, 3) == 0);
      n2 = ($urandom_range(0, 3) == 0);
`ifdef I2C_TX_BURST_EN
      tg = 1'b0;
`else
      tg = 1'($urandom_range(0, 1));
`endif
      run_txn(rd, n1, n2, tg, 1'b0, 8'h00, 0);
    end

`ifdef I2C_TX_BURST_EN
    run_txn(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
